// File: rtl/fsd_scan_driver.sv
// Multiplexed fourteen-segment scan driver: double-buffered ASCII display with frame PWM
// brightness. Define FSD_SCAN_BLINK_EN to compile in per-digit blinking.
module fsd_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int DWELL        = 1,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   chars,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [14:0]           seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame_start
);
  localparam int DW_W  = (DWELL > 1)  ? $clog2(DWELL)  : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Active-low glyphs; lowercase folds to uppercase, anything unmapped is blank.
  function automatic logic [13:0] font(input logic [7:0] c);
    logic [7:0]  u;
    logic [13:0] on;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h30: on = 14'h003F;  8'h31: on = 14'h0406;
      8'h32: on = 14'h00DB;  8'h33: on = 14'h008F;
      8'h34: on = 14'h00E6;  8'h35: on = 14'h00ED;
      8'h36: on = 14'h00FD;  8'h37: on = 14'h0007;
      8'h38: on = 14'h00FF;  8'h39: on = 14'h00EF;
      8'h41: on = 14'h00F7;  8'h42: on = 14'h128F;
      8'h43: on = 14'h0039;  8'h44: on = 14'h120F;
      8'h45: on = 14'h00F9;  8'h46: on = 14'h0071;
      8'h47: on = 14'h00BD;  8'h48: on = 14'h00F6;
      8'h49: on = 14'h1209;  8'h4A: on = 14'h001E;
      8'h4B: on = 14'h2470;  8'h4C: on = 14'h0038;
      8'h4D: on = 14'h0536;  8'h4E: on = 14'h2136;
      8'h4F: on = 14'h003F;  8'h50: on = 14'h00F3;
      8'h51: on = 14'h203F;  8'h52: on = 14'h20F3;
      8'h53: on = 14'h018D;  8'h54: on = 14'h1201;
      8'h55: on = 14'h003E;  8'h56: on = 14'h0C30;
      8'h57: on = 14'h2836;  8'h58: on = 14'h2D00;
      8'h59: on = 14'h1500;  8'h5A: on = 14'h0C09;
      8'h2D: on = 14'h00C0;
      default: on = 14'h0000;
    endcase
    return ~on;
  endfunction

  logic                       run;
  logic [IDX_W-1:0]           idx, nxt_idx;
  logic [DW_W-1:0]            dwell_cnt, nxt_dwell;
  logic                       boundary;
  logic [DIGITS-1:0][7:0]     act_chars, pend_chars, nxt_chars;
  logic [DIGITS-1:0]          act_dp, pend_dp, nxt_dp;
  logic                       pend_valid;
  logic [BRIGHT_W-1:0]        pwm_cnt, nxt_pwm;
  logic                       lit, blanked;

  // run is low only for the first edge after reset, which presents digit 0 as a boundary.
  always_comb begin
    nxt_idx   = idx;
    nxt_dwell = dwell_cnt;
    boundary  = 1'b0;
    if (!run) begin
      nxt_idx   = '0;
      nxt_dwell = '0;
      boundary  = 1'b1;
    end else if (dwell_cnt == DW_W'(DWELL - 1)) begin
      nxt_dwell = '0;
      if (idx == IDX_W'(DIGITS - 1)) begin
        nxt_idx  = '0;
        boundary = 1'b1;
      end else begin
        nxt_idx = idx + IDX_W'(1);
      end
    end else begin
      nxt_dwell = dwell_cnt + DW_W'(1);
    end
  end

  always_comb begin
    nxt_chars = act_chars;
    nxt_dp    = act_dp;
    if (boundary) begin
      if (load) begin
        nxt_chars = chars;
        nxt_dp    = dp;
      end else if (pend_valid) begin
        nxt_chars = pend_chars;
        nxt_dp    = pend_dp;
      end
    end
  end

  // pwm_cnt holds the current frame's level, so the reset-release frame uses level 0.
  assign nxt_pwm = (boundary && run) ? pwm_cnt + BRIGHT_W'(1) : pwm_cnt;
  assign lit     = (nxt_pwm <= brightness);

`ifdef FSD_SCAN_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BC_W-1:0] blink_cnt, nxt_bcnt;
  logic            blink_phase, nxt_phase;

  always_comb begin
    nxt_bcnt  = blink_cnt;
    nxt_phase = blink_phase;
    if (boundary && run) begin
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        nxt_bcnt  = '0;
        nxt_phase = ~blink_phase;
      end else begin
        nxt_bcnt = blink_cnt + BC_W'(1);
      end
    end
  end

  assign blanked = nxt_phase & blink_mask[nxt_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= nxt_bcnt;
      blink_phase <= nxt_phase;
    end
  end
`else
  localparam int blink_frames_unused = BLINK_FRAMES;
  logic blink_unused;
  assign blink_unused = ^blink_mask;
  assign blanked      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run        <= 1'b0;
      idx        <= '0;
      dwell_cnt  <= '0;
      pwm_cnt    <= '0;
      act_chars  <= {DIGITS{8'h20}};
      act_dp     <= '1;
      pend_chars <= {DIGITS{8'h20}};
      pend_dp    <= '1;
      pend_valid <= 1'b0;
    end else begin
      run       <= 1'b1;
      idx       <= nxt_idx;
      dwell_cnt <= nxt_dwell;
      pwm_cnt   <= nxt_pwm;
      act_chars <= nxt_chars;
      act_dp    <= nxt_dp;
      if (load) begin
        pend_chars <= chars;
        pend_dp    <= dp;
      end
      if (boundary)  pend_valid <= 1'b0;
      else if (load) pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg         <= 15'h7FFF;
      dig         <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (!lit) begin
        seg <= '1;
        dig <= '1;
      end else begin
        dig <= ~(DIGITS'(1) << nxt_idx);
        seg <= blanked ? 15'h7FFF : {nxt_dp[nxt_idx], font(nxt_chars[nxt_idx])};
      end
    end
  end
endmodule

// File: tb/tb_fsd_scan_driver.sv
// Self-checking bench for fsd_scan_driver: directed scenarios plus randomized traffic,
// all checked against a frame-arithmetic reference model.
module tb_fsd_scan_driver;
  localparam int DIGITS = 4, DWELL = 1, BRIGHT_W = 3, BF = 2;
  localparam int FL = DIGITS * DWELL;
`ifdef FSD_SCAN_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic                  clk, reset, load;
  logic [8*DIGITS-1:0]   chars;
  logic [DIGITS-1:0]     dp, blink_mask, dig;
  logic [BRIGHT_W-1:0]   brightness;
  logic [14:0]           seg;
  logic                  frame_start;

  int tests = 0;
  int fails = 0;

  fsd_scan_driver #(.DIGITS(DIGITS), .DWELL(DWELL), .BRIGHT_W(BRIGHT_W), .BLINK_FRAMES(BF)) u_dut (
    .clk(clk), .reset(reset), .chars(chars), .dp(dp), .load(load),
    .brightness(brightness), .blink_mask(blink_mask),
    .seg(seg), .dig(dig), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position n since reset release, frame = n / FL,
  // and the last load seen up to a frame start becomes that frame's data.
  int                m_n;
  logic [7:0]        m_chars [DIGITS];
  logic [DIGITS-1:0] m_dp;
  bit                ld_have;
  logic [8*DIGITS-1:0] ld_chars;
  logic [DIGITS-1:0] ld_dp;
  logic [14:0]       exp_seg;
  logic [DIGITS-1:0] exp_dig;
  logic              exp_fs;

  function automatic logic [13:0] tb_font(input logic [7:0] c);
    case (c)
      "0": return 14'b11_1111_1100_0000;
      "1": return 14'b11_1011_1111_1001;
      "2": return ~14'h00DB;
      "3": return ~14'h008F;
      "4": return ~14'h00E6;
      "5": return ~14'h00ED;
      "6": return ~14'h00FD;
      "7": return ~14'h0007;
      "8": return ~14'h00FF;
      "9": return ~14'h00EF;
      default: return 14'h3FFF;
    endcase
  endfunction

  function automatic logic [7:0] rnd_char();
    int k;
    k = $urandom_range(0, 11);
    if (k < 10) return 8'h30 + 8'(k);
    if (k == 10) return 8'h20;
    return 8'h23;
  endfunction

  task automatic model_step();
    int p, f, d;
    bit lit, blank;
    if (reset) begin
      m_n = 0;
      for (int k = 0; k < DIGITS; k++) m_chars[k] = 8'h20;
      m_dp    = '1;
      ld_have = 1'b0;
      exp_seg = 15'h7FFF;
      exp_dig = '1;
      exp_fs  = 1'b0;
      return;
    end
    p = m_n % FL;
    f = m_n / FL;
    m_n++;
    if (load) begin
      ld_have  = 1'b1;
      ld_chars = chars;
      ld_dp    = dp;
    end
    if (p == 0 && ld_have) begin
      for (int k = 0; k < DIGITS; k++) m_chars[k] = ld_chars[8*k +: 8];
      m_dp    = ld_dp;
      ld_have = 1'b0;
    end
    d     = p / DWELL;
    lit   = (f % (1 << BRIGHT_W)) <= int'(brightness);
    blank = BLINK_EN && ((f / BF) % 2 == 1) && blink_mask[d];
    exp_fs  = (p == 0);
    exp_dig = lit ? ~(DIGITS'(1) << d) : '1;
    exp_seg = (!lit || blank) ? 15'h7FFF : {m_dp[d], tb_font(m_chars[d])};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    chars = $urandom(); dp = DIGITS'($urandom()); load = 1'($urandom());
    blink_mask = DIGITS'($urandom()); brightness = BRIGHT_W'($urandom());
    #1 reset = 1'b1;
    model_step();
    #1;
    tests++;
    if ({seg, dig, frame_start} !== {15'h7FFF, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL reset_async: got seg=%h dig=%b fs=%b, want 7fff 1111 0", seg, dig, frame_start);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({seg, dig, frame_start} !== {15'h7FFF, 4'b1111, 1'b0}) begin
        fails++;
        $display("FAIL reset_held%0d: got seg=%h dig=%b fs=%b, want 7fff 1111 0", i, seg, dig, frame_start);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] seq [4];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    brightness = '1; blink_mask = '0;
    load = 1'b1; chars = 32'h30303030; dp = 4'b1111;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0;
      tests++;
      if ({seg, dig, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL basic_scan%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_seg, exp_dig, exp_fs);
      end
      tests++;
      if ({seg, dig, frame_start} !== {15'b111_1111_1100_0000, seq[i % 4], 1'(i % 4 == 0)}) begin
        fails++;
        $display("FAIL basic_const%0d: got seg=%b dig=%b fs=%b, want seg=111111111000000 dig=%b",
                 i, seg, dig, frame_start, seq[i % 4]);
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [14:0] want;
    tick();
    tick();
    load = 1'b1; chars = 32'h31313131; dp = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0;
      want = (i < 2) ? 15'b111_1111_1100_0000 : 15'b011_1011_1111_1001;
      tests++;
      if ({seg, dig, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL midload%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_seg, exp_dig, exp_fs);
      end
      tests++;
      if (seg !== want) begin
        fails++;
        $display("FAIL midload_seg%0d: got seg=%b, want %b", i, seg, want);
      end
    end
  endtask

  task automatic test_brightness();
    int pulses;
    pulses = 0;
    brightness = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (frame_start === 1'b1) pulses++;
      tests++;
      if ({seg, dig, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL bright%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_seg, exp_dig, exp_fs);
      end
    end
    tests++;
    if (pulses != 16) begin
      fails++;
      $display("FAIL bright_frame_pulses: got %0d, want 16", pulses);
    end
    brightness = '1;
  endtask

  task automatic test_blink();
    blink_mask = 4'b0001;
    for (int i = 0; i < 48; i++) begin
      tick();
      tests++;
      if ({seg, dig, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL blink%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_seg, exp_dig, exp_fs);
      end
    end
    blink_mask = '0;
  endtask

  task automatic test_reset_midframe();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (exp_dig == 4'b1101) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL rst_mid_seek: digit 1 not reached within 8 cycles, got dig=%b", dig);
    end
    load = 1'b1; chars = 32'h31313131; dp = 4'b0000;
    tick();
    load = 1'b0;
    #2 reset = 1'b1;
    model_step();
    #1;
    tests++;
    if ({seg, dig, frame_start} !== {15'h7FFF, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid_async: got seg=%h dig=%b fs=%b, want 7fff 1111 0", seg, dig, frame_start);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if ({seg, dig, frame_start} !== {15'h7FFF, (i % 4 == 0) ? 4'b1110 : exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL rst_mid_restart%0d: got seg=%h dig=%b fs=%b, want seg=7fff dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_dig, exp_fs);
      end
      tests++;
      if ({seg, dig, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL rst_mid_model%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_seg, exp_dig, exp_fs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < DIGITS; k++) chars[8*k +: 8] = rnd_char();
      dp = DIGITS'($urandom());
      if ($urandom_range(0, 15) == 0) brightness = BRIGHT_W'($urandom());
      if ($urandom_range(0, 15) == 0) blink_mask = DIGITS'($urandom());
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        model_step();
        #1;
        tests++;
        if ({seg, dig, frame_start} !== {15'h7FFF, 4'b1111, 1'b0}) begin
          fails++;
          $display("FAIL rnd_async_reset%0d: got seg=%h dig=%b fs=%b", i, seg, dig, frame_start);
        end
        tick();
        reset = 1'b0;
      end
      tick();
      tests++;
      if ({seg, dig, frame_start} !== {exp_seg, exp_dig, exp_fs}) begin
        fails++;
        $display("FAIL random%0d: got seg=%h dig=%b fs=%b, want seg=%h dig=%b fs=%b",
                 i, seg, dig, frame_start, exp_seg, exp_dig, exp_fs);
      end
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; chars = '0; dp = '1;
    brightness = '1; blink_mask = '0;
    m_n = 0; m_dp = '1; ld_have = 1'b0; ld_chars = '0; ld_dp = '1;
    exp_seg = 15'h7FFF; exp_dig = '1; exp_fs = 1'b0;
    for (int k = 0; k < DIGITS; k++) m_chars[k] = 8'h20;
    test_reset();
    test_basic_scan();
    test_midframe_load();
    test_brightness();
    test_blink();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fsd_scan_driver.md
# fsd_scan_driver

- Parametrised, multiplexed fourteen-segment display scan driver for `DIGITS` positions.
- Generalises the fixed 4-digit encoder with:
  - configurable per-digit dwell;
  - tear-free double-buffered loads that apply at frame boundaries;
  - frame-level PWM brightness;
  - optional per-digit blinking.
- It sits between the register/bus logic that supplies ASCII characters and the board's active-low segment and digit pins.
- Glyph lookup reuses the team's existing fourteen-segment font encoding.

## Interface
- `DIGITS`, 4, number of multiplexed digit positions (≥1)
- `DWELL`, 1, clock cycles each digit stays selected (≥1)
- `BRIGHT_W`, 3, width of the brightness input
- `BLINK_FRAMES`, 8, frames per blink half-period (≥1)

- `clk`  in  1  scan clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `chars`  in  8*DIGITS  ASCII characters; digit k is `chars[8k+7:8k]`
- `dp`  in  DIGITS  decimal points, active-low (0 = lit)
- `load`  in  1  capture `chars`/`dp` into the pending buffer this cycle
- `brightness`  in  BRIGHT_W  PWM level; all-ones = always lit
- `blink_mask`  in  DIGITS  1 = digit blinks
- `seg`  out  15  active-low segments; `seg[14]` = decimal point, `seg[13:0]` = glyph
- `dig`  out  DIGITS  active-low one-cold digit select
- `frame_start`  out  1  one-cycle pulse, high while digit 0 is first presented

## Operation
- **Buffers:**
  - Pending buffer: `{chars, dp}` plus a `pend_valid` flag.
  - Active buffer drives the display.
  - `load` = 1 captures into pending and sets `pend_valid`. Repeated loads before the boundary: the last one wins.
- **Frame boundary:** the edge on which the digit index wraps from DIGITS-1 to 0.
  - At the boundary: active ← inputs if `load` = 1 on that edge; otherwise ← pending if `pend_valid`; otherwise unchanged.
  - `pend_valid` clears at the boundary.
  - Data never changes mid-frame.
- **Scan counters:**
  - `dwell_cnt` counts 0..DWELL-1. Its width is `$clog2(DWELL)`, minimum 1 bit.
  - The digit index advances when `dwell_cnt` = DWELL-1.
  - DIGITS = 1: every advance is a boundary.
- **Glyph:**
  - `seg[13:0]` = font(active char of current digit); `seg[14]` = active dp bit.
  - Space and unmapped codes give all ones.
  - Font references: "0" = 14'b11_1111_1100_0000; "1" = 14'b11_1011_1111_1001.
- **Brightness:**
  - `pwm_cnt` (BRIGHT_W bits) increments at each boundary and wraps.
  - A frame is lit iff `pwm_cnt` ≤ `brightness`.
  - An unlit frame forces `seg` and `dig` to all ones. Scanning and `frame_start` continue.
- **Blink:**
  - `blink_cnt` counts frames 0..BLINK_FRAMES-1; `blink_phase` toggles on wrap. Phase 0 = visible.
  - In phase 1, digits with a `blink_mask` bit set output `seg` all ones; `dig` still selects them.
- **Outputs:** all outputs are registered.

## Timing
- **Reset** (asynchronous, immediate; also applies when asserted mid-frame):
  - `seg` = 15'h7FFF, `dig` = all ones, `frame_start` = 0.
  - Index 0, all counters 0, `blink_phase` 0.
  - Active chars = spaces, active dp = all ones, `pend_valid` = 0.
- **First edge after release:** `dig` = ~1 (digit 0) and `frame_start` = 1.
  - Reset release counts as a boundary, so a `load` held on that edge applies immediately.
- **Digit sequence:** digit k is presented for DWELL cycles. Frame length is DIGITS*DWELL cycles.
- **Load latency:** a `load` during frame n appears from frame n+1. A `load` on a boundary edge appears in the frame starting at that edge.
- **Input timing:** `brightness` and `blink_mask` are sampled every cycle with no buffering. A change takes effect on the next registered output.
- **Counter wrap:** `pwm_cnt` and `blink_cnt` wrap silently with no flags.

## Configuration
- Macro: `FSD_SCAN_BLINK_EN`.
- **Defined:** the blink counter, blink phase and `blink_mask` gating are compiled in, as described above.
- **Undefined:** `blink_mask` is ignored, blink logic is absent, and digits are never blanked by blink.

## Test plan
All scenarios use DIGITS = 4, DWELL = 1, `brightness` = 3'b111 unless noted.

1. **Reset:** `reset` held high with arbitrary inputs -> `seg` = 15'h7FFF, `dig` = 4'b1111, `frame_start` = 0.
2. **Basic scan:** `load` = 1 with chars "0000", `dp` = 4'b1111, held at reset release -> for 8 cycles:
   - `dig` cycles 1110, 1101, 1011, 0111 (twice);
   - `seg` = 15'b111_1111_1100_0000;
   - `frame_start` high on each 1110.
3. **Mid-frame load:** one-cycle `load` of "1111", `dp` = 4'b0000, while digit 1 is shown ->
   - digits 2 and 3 of that frame still show 15'b111_1111_1100_0000;
   - from the next 1110 onward, `seg` = 15'b011_1011_1111_1001.
4. **Brightness:** `brightness` = 0 -> one frame lit, then 7 frames with `seg`/`dig` all ones. The pattern repeats every 32 cycles and `frame_start` keeps pulsing.
5. **Blink:** `blink_mask` = 4'b0001, BLINK_FRAMES = 2.
   - With `FSD_SCAN_BLINK_EN`: digit 0 `seg` = all ones in frames 2-3, 6-7, ...; the other digits are unaffected.
   - Without the macro: never blanked.
6. **Reset mid-frame:** assert `reset` while digit 2 is shown -> outputs go all ones without waiting for a clock edge. After release, the scan restarts at 1110 with blank (space) glyphs and `pend_valid` cleared.
